// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the SRAM-like responder: size codes, FSM states
// and the byte-enable decode used on the write path.
package sram_like_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Size code 3 is treated as a full word.
  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] addrLo);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addrLo;
      SIZE_HALF: be = addrLo[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_like_responder_be_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port. Array contents are never reset; only the read register is.
module be_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] rdataR;

  // Byte-lane writes; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register only loads on a read access, so writes leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdataR <= 32'h0000_0000;
    end else if (en && (we == 4'b0000)) begin
      rdataR <= mem[addr];
    end
  end

  assign rdata = rdataR;

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like slave: one outstanding transfer, fixed LATENCY from acceptance
// to the data_ok pulse, backed by a byte-enabled RAM.
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_e                state;
  logic [3:0]            waitCnt;
  logic                  handshake;
  logic [3:0]            ramWe;
  logic [DEPTH_LOG2-1:0] wordIdx;

  assign addr_ok   = (state == IDLE) || (state == RESP);
  assign data_ok   = (state == RESP);
  assign handshake = req && addr_ok;
  // Upper address bits are dropped so accesses wrap modulo the RAM size.
  assign wordIdx   = addr[DEPTH_LOG2+1:2];

  // Write enables are only raised for an accepted write.
  always_comb begin
    ramWe = 4'b0000;
    if (handshake && wr) begin
      ramWe = byteEnable(size, addr[1:0]);
    end else begin
      ramWe = 4'b0000;
    end
  end

  // Transfer FSM with latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (handshake) begin
            state   <= (LATENCY == 1) ? RESP : WAIT;
            waitCnt <= CNT_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (waitCnt == 4'd0) begin
            state <= RESP;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          waitCnt <= 4'd0;
        end
      endcase
    end
  end

  be_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) uRam (
    .clk   (clk),
    .rst   (rst),
    .en    (handshake),
    .we    (ramWe),
    .addr  (wordIdx),
    .wdata (wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: a LATENCY=2 instance for function/reset/wrap checks and a
// LATENCY=1 instance for back-to-back streaming.
module tb_sram_like_responder;

  logic clk = 1'b0;
  logic rst;

  logic        reqA, wrA;
  logic [1:0]  sizeA;
  logic [31:0] addrA, wdataA, rdataA;
  logic        addrOkA, dataOkA;

  logic        reqB, wrB;
  logic [1:0]  sizeB;
  logic [31:0] addrB, wdataB, rdataB;
  logic        addrOkB, dataOkB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_like_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dutA (
    .clk(clk), .rst(rst), .req(reqA), .wr(wrA), .size(sizeA), .addr(addrA),
    .wdata(wdataA), .addr_ok(addrOkA), .data_ok(dataOkA), .rdata(rdataA)
  );

  sram_like_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dutB (
    .clk(clk), .rst(rst), .req(reqB), .wr(wrB), .size(sizeB), .addr(addrB),
    .wdata(wdataB), .addr_ok(addrOkB), .data_ok(dataOkB), .rdata(rdataB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one transfer on instance A at a negedge; returns at the negedge
  // where data_ok is seen (bounded), having checked latency and rdata.
  task automatic xferA(input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] expRd, input string tag);
    int n;
    reqA = 1'b1; wrA = w; sizeA = s; addrA = a; wdataA = d;
    check({tag, "_addr_ok"}, {31'd0, addrOkA}, 32'd1);
    @(negedge clk);
    reqA = 1'b0; wrA = 1'b1; sizeA = 2'd2; wdataA = 32'hFFFF_FFFF; addrA = 32'h0;
    n = 1;
    while (!dataOkA && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 32'd2);
    check({tag, "_rdata"}, rdataA, expRd);
  endtask

  initial begin
    logic [31:0] bw [4];
    bit seen;
    bw[0] = 32'h0102_0304; bw[1] = 32'hA0B0_C0D0;
    bw[2] = 32'h5555_AAAA; bw[3] = 32'h0F0F_F0F0;

    rst = 1'b1;
    reqA = 1'b0; wrA = 1'b0; sizeA = 2'd0; addrA = 32'h0; wdataA = 32'h0;
    reqB = 1'b0; wrB = 1'b0; sizeB = 2'd0; addrB = 32'h0; wdataB = 32'h0;
    @(negedge clk);
    check("rst_addr_ok", {31'd0, addrOkA}, 32'd1);
    check("rst_data_ok", {31'd0, dataOkA}, 32'd0);
    check("rst_rdata", rdataA, 32'h0);
    check("rst_addr_ok_b", {31'd0, addrOkB}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Basic word write/read; the write must not disturb rdata.
    xferA(1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, "wr_dead");
    xferA(1'b0, 2'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, "rd_dead");

    // Mixed-size merge into one word.
    xferA(1'b1, 2'd2, 32'h20, 32'h1122_3344, 32'hDEAD_BEEF, "wr_w20");
    xferA(1'b1, 2'd0, 32'h22, 32'h00AA_0000, 32'hDEAD_BEEF, "wr_b22");
    xferA(1'b1, 2'd1, 32'h20, 32'h0000_BBCC, 32'hDEAD_BEEF, "wr_h20");
    xferA(1'b0, 2'd2, 32'h20, 32'h0, 32'h11AA_BBCC, "rd_20");

    // Byte lane 3, upper halfword, and size 3 with misaligned address.
    xferA(1'b1, 2'd0, 32'h13, 32'h7700_0000, 32'h11AA_BBCC, "wr_b13");
    xferA(1'b1, 2'd1, 32'h22, 32'h9988_0000, 32'h11AA_BBCC, "wr_h22");
    xferA(1'b1, 2'd3, 32'h33, 32'hA5A5_A5A5, 32'h11AA_BBCC, "wr_s3");
    xferA(1'b0, 2'd2, 32'h10, 32'h0, 32'h77AD_BEEF, "rd_10b");
    xferA(1'b0, 2'd2, 32'h20, 32'h0, 32'h9988_BBCC, "rd_20b");
    xferA(1'b0, 2'd2, 32'h30, 32'h0, 32'hA5A5_A5A5, "rd_30");

    // Address wrap at 4 KiB.
    xferA(1'b1, 2'd2, 32'h0000_1004, 32'h1234_5678, 32'hA5A5_A5A5, "wr_wrap");
    xferA(1'b0, 2'd2, 32'h0000_0004, 32'h0, 32'h1234_5678, "rd_wrap");

    // Read issued in the write's data_ok cycle sees the write.
    @(negedge clk);
    xferA(1'b1, 2'd2, 32'h40, 32'hCAFE_F00D, 32'h1234_5678, "wr_40");
    xferA(1'b0, 2'd2, 32'h40, 32'h0, 32'hCAFE_F00D, "rd_40_b2b");

    // Reset while waiting on a read.
    @(negedge clk);
    reqA = 1'b1; wrA = 1'b0; sizeA = 2'd2; addrA = 32'h10;
    @(negedge clk);
    reqA = 1'b0;
    check("wait_data_ok", {31'd0, dataOkA}, 32'd0);
    check("wait_addr_ok", {31'd0, addrOkA}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("midrst_addr_ok", {31'd0, addrOkA}, 32'd1);
    check("midrst_rdata", rdataA, 32'h0);
    check("midrst_data_ok", {31'd0, dataOkA}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dataOkA) seen = 1'b1;
    end
    check("postrst_no_data_ok", {31'd0, seen}, 32'd0);
    xferA(1'b0, 2'd2, 32'h10, 32'h0, 32'h77AD_BEEF, "rd_persist");

    // LATENCY=1 streaming: req held high, one transfer per cycle.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      reqB = 1'b1; wrB = 1'b1; sizeB = 2'd2; addrB = 32'h100 + 32'(4*i); wdataB = bw[i];
      @(negedge clk);
      check("b_wr_addr_ok", {31'd0, addrOkB}, 32'd1);
      check("b_wr_data_ok", {31'd0, dataOkB}, 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      reqB = 1'b1; wrB = 1'b0; addrB = 32'h100 + 32'(4*i); wdataB = 32'h0;
      @(negedge clk);
      check("b_rd_addr_ok", {31'd0, addrOkB}, 32'd1);
      check("b_rd_data_ok", {31'd0, dataOkB}, 32'd1);
      check("b_rd_rdata", rdataB, bw[i]);
    end
    reqB = 1'b0;
    @(negedge clk);
    check("b_idle_data_ok", {31'd0, dataOkB}, 32'd0);
    check("b_hold_rdata", rdataB, bw[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_like_responder.md
SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 10, meaning the word-address width of the internal memory (2^DEPTH_LOG2 32-bit words).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from the accepting edge to the data_ok cycle; legal range is 1..15.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req, input, width 1: the initiator requests a transfer.
REQ-006 The block SHALL have port wr, input, width 1: 1 = write, 0 = read.
REQ-007 The block SHALL have port size, input, width 2: 0 = byte, 1 = halfword, 2 = word, 3 = treated as word.
REQ-008 The block SHALL have port addr, input, width 32: byte address.
REQ-009 The block SHALL have port wdata, input, width 32: write data, byte lanes already aligned by the initiator.
REQ-010 The block SHALL have port addr_ok, output, width 1: the request is accepted in this cycle when req is also 1.
REQ-011 The block SHALL have port data_ok, output, width 1: one-cycle pulse that completes the oldest accepted transfer.
REQ-012 The block SHALL have port rdata, output, width 32: the full addressed word, valid while data_ok is 1.

Function
REQ-013 The block SHALL accept a transfer ("handshake") on a rising edge where req=1 and addr_ok=1; at most one transfer SHALL be outstanding.
REQ-014 The block SHALL implement FSM states IDLE, WAIT and RESP.
- Handshake from IDLE or RESP -> RESP when LATENCY=1, else -> WAIT.
- WAIT -> RESP when the latency counter expires.
- RESP without handshake -> IDLE.
REQ-015 addr_ok SHALL be 1 exactly when the state is IDLE or RESP, combinationally and independent of req, giving back-to-back throughput of one transfer per LATENCY cycles.
REQ-016 data_ok SHALL be 1 exactly when the state is RESP; with handshake at edge T, data_ok SHALL be high in the cycle following edge T+LATENCY-1 (LATENCY cycles after acceptance).
REQ-017 The WAIT counter SHALL be 4 bits, SHALL load LATENCY-2 on handshake, and SHALL decrement to 0, at which point the next edge enters RESP.
REQ-018 The word index SHALL be addr[DEPTH_LOG2+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo the memory size.
REQ-019 Byte enables for writes SHALL be:
- size 0: 1<<addr[1:0].
- size 1: addr[1] ? 4'b1100 : 4'b0011.
- size 2/3: 4'b1111, with addr[1:0] ignored.
REQ-020 Memory SHALL be written on the handshake edge with the enabled bytes of wdata; disabled bytes SHALL be unchanged.
REQ-021 Reads SHALL capture the whole word into the rdata register on the handshake edge; a read accepted in the same cycle as data_ok of a prior write SHALL observe that write.
REQ-022 rdata SHALL hold its value until the next read's capture; writes SHALL leave rdata unchanged.
REQ-023 Changes on req, wr, size, addr or wdata outside a handshake SHALL have no effect.

Reset
REQ-024 On rst=1 the block SHALL immediately go to state IDLE, with data_ok=0, addr_ok=1, rdata=32'h0 and the counter at 0.
REQ-025 Reset mid-transfer SHALL discard the outstanding transfer and produce no data_ok.
REQ-026 Memory contents SHALL NOT be reset; a write already committed on its handshake edge SHALL persist through reset.

Structure
REQ-027 The size encodings (SIZE_BYTE/HALF/WORD) and the FSM state encodings SHALL live in the shared sram-like definitions header used by the core and bridge.
REQ-028 The memory SHALL be a sub-module be_ram: single port, synchronous, 4 byte-write enables, read data registered, DEPTH_LOG2 parameter.

Verification
REQ-029 With LATENCY=2, word write of 32'hDEADBEEF to addr 32'h10, then word read of 32'h10 -> data_ok 2 cycles after each handshake, rdata=32'hDEADBEEF.
REQ-030 Word write of 32'h11223344 to 32'h20, byte write of wdata=32'h00AA0000 to 32'h22, halfword write of wdata=32'h0000BBCC to 32'h20, then read 32'h20 -> rdata=32'h11AABBCC.
REQ-031 With LATENCY=1, req held high for 4 reads -> addr_ok and data_ok high every cycle, 4 data_ok pulses in 5 cycles, in order.
REQ-032 With DEPTH_LOG2=10, write to 32'h0000_1004 then read 32'h0000_0004 -> same word returned (wrap).
REQ-033 rst asserted in WAIT after a read handshake -> data_ok never pulses, addr_ok=1 and rdata=0 immediately.
REQ-034 Write handshake, then a read of the same address accepted in the write's data_ok cycle -> the read returns the written data; addr_ok stays high across the boundary.
